// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing constants, pattern modes, RGB332 colours and handshake states.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SOLID  = 2'd0,
    BARS   = 2'd1,
    CHECK  = 2'd2,
    SCROLL = 2'd3
  } vga_mode_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } hs_state_t;

  // RGB332 byte layout: [7:6] b, [5:3] g, [2:0] r
  localparam logic [7:0] RGB_WHITE   = 8'hFF;
  localparam logic [7:0] RGB_YELLOW  = 8'h3F;
  localparam logic [7:0] RGB_CYAN    = 8'hF8;
  localparam logic [7:0] RGB_GREEN   = 8'h38;
  localparam logic [7:0] RGB_MAGENTA = 8'hC7;
  localparam logic [7:0] RGB_RED     = 8'h07;
  localparam logic [7:0] RGB_BLUE    = 8'hC0;
  localparam logic [7:0] RGB_BLACK   = 8'h00;

endpackage

// File: rtl/vga_bar_lut.sv
// Colour-bar lookup: 3-bit bar index to RGB332 colour, combinational.
module vga_bar_lut
  import vga_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] color_c
);

  always_comb begin
    color_c = RGB_BLACK;
    case (idx)
      3'd0:    color_c = RGB_WHITE;
      3'd1:    color_c = RGB_YELLOW;
      3'd2:    color_c = RGB_CYAN;
      3'd3:    color_c = RGB_GREEN;
      3'd4:    color_c = RGB_MAGENTA;
      3'd5:    color_c = RGB_RED;
      3'd6:    color_c = RGB_BLUE;
      default: color_c = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_pattern_src.sv
// VGA pixel source: raster counters, RGB332 test patterns, frame-synchronous mode handshake.
// Define VGA_PATTERN_SCROLL_EN to make mode 3 scroll the colour bars; otherwise mode 3 equals mode 1.
module vga_pattern_src #(
  parameter int unsigned H_TOTAL    = vga_pkg::H_TOTAL,
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned V_TOTAL    = vga_pkg::V_TOTAL,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned BAR_W      = 80,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic [1:0] mode_sel,
  input  logic       mode_req,
  input  logic [7:0] fill_color,
  output logic       mode_ack,
  output logic [7:0] data,
  output logic       frame_start,
  output logic       active
);
  import vga_pkg::*;

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_last;
  logic          frame_end;
  logic          visible;

  hs_state_t     state;
  hs_state_t     state_nxt;
  logic          capture;
  logic          apply;
  vga_mode_t     cur_mode;
  vga_mode_t     sh_mode;
  logic [7:0]    cur_color;
  logic [7:0]    sh_color;

  logic [2:0]    bar_idx;
  logic [7:0]    bar_color;
  logic [7:0]    pix;

  always_comb begin
    h_last    = (hcnt == HW'(H_TOTAL - 1));
    frame_end = h_last && (vcnt == VW'(V_TOTAL - 1));
    visible   = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  end

`ifdef VGA_PATTERN_SCROLL_EN
  logic [HW-1:0] offset;
  logic [HW:0]   scroll_sum;
  logic [HW:0]   scroll_x;

  // Both operands are below H_ACTIVE when visible, so one conditional subtract gives the modulo
  always_comb begin
    scroll_sum = {1'b0, hcnt} + {1'b0, offset};
    scroll_x   = (scroll_sum >= (HW+1)'(H_ACTIVE)) ? scroll_sum - (HW+1)'(H_ACTIVE) : scroll_sum;
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      offset <= '0;
    end else if (frame_end) begin
      offset <= (offset == HW'(H_ACTIVE - 1)) ? '0 : offset + HW'(1);
    end
  end
`endif

  always_comb begin
    bar_idx = 3'(32'(hcnt) / BAR_W);
`ifdef VGA_PATTERN_SCROLL_EN
    if (cur_mode == SCROLL) begin
      bar_idx = 3'(32'(scroll_x) / BAR_W);
    end
`endif
  end

  vga_bar_lut u_bar_lut (
    .idx     (bar_idx),
    .color_c (bar_color)
  );

  always_comb begin
    pix = 8'h00;
    if (visible) begin
      case (cur_mode)
        SOLID:   pix = cur_color;
        CHECK:   pix = (hcnt[CHECK_LOG2] ^ vcnt[CHECK_LOG2]) ? ~cur_color : cur_color;
        default: pix = bar_color;
      endcase
    end
  end

  // Handshake: first request captured in IDLE is held until the next frame boundary
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (mode_req) begin
          capture   = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      sh_mode     <= BARS;
      sh_color    <= 8'h00;
      cur_mode    <= BARS;
      cur_color   <= 8'h00;
      mode_ack    <= 1'b0;
      data        <= 8'h00;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcnt <= h_last ? '0 : hcnt + HW'(1);
      if (h_last) begin
        vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
      end
      if (capture) begin
        sh_mode  <= vga_mode_t'(mode_sel);
        sh_color <= fill_color;
      end
      if (apply) begin
        cur_mode  <= sh_mode;
        cur_color <= sh_color;
      end
      mode_ack    <= apply;
      data        <= pix;
      active      <= visible;
      frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_pattern_src.sv
// Scoreboard bench for vga_pattern_src on a reduced 100x12 raster (80x10 visible, 10-pixel bars, 4-pixel checker).
module tb_vga_pattern_src;

  localparam int unsigned TB_H_TOTAL  = 100;
  localparam int unsigned TB_H_ACTIVE = 80;
  localparam int unsigned TB_V_TOTAL  = 12;
  localparam int unsigned TB_V_ACTIVE = 10;

  logic       dclk = 1'b0;
  logic       rst;
  logic [1:0] mode_sel;
  logic       mode_req;
  logic [7:0] fill_color;
  logic       mode_ack;
  logic [7:0] data;
  logic       frame_start;
  logic       active;

  vga_pattern_src #(
    .H_TOTAL    (TB_H_TOTAL),
    .H_ACTIVE   (TB_H_ACTIVE),
    .V_TOTAL    (TB_V_TOTAL),
    .V_ACTIVE   (TB_V_ACTIVE),
    .BAR_W      (10),
    .CHECK_LOG2 (2)
  ) dut (
    .dclk        (dclk),
    .rst         (rst),
    .mode_sel    (mode_sel),
    .mode_req    (mode_req),
    .fill_color  (fill_color),
    .mode_ack    (mode_ack),
    .data        (data),
    .frame_start (frame_start),
    .active      (active)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    int         seg;
    int         p;
    logic [7:0] data;
    logic       act;
    logic       fs;
    logic       ack;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   n          = 0;
  int   seg        = 0;
  int   ack_cnt    = 0;
  bit   mon_en     = 1'b0;

  // Edges since reset release; output stream position is n-1 (outputs lag counters by one)
  always @(posedge dclk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  always @(negedge dclk) begin : monitor
    exp_t e;
    int   p;
    if (mon_en) begin
      p = n - 1;
      if (mode_ack === 1'b1) ack_cnt++;
      while (q.size() > 0 && (q[0].seg < seg || (q[0].seg == seg && q[0].p <= p))) begin
        e = q.pop_front();
        compared++;
        if (e.seg != seg || e.p != p) begin
          mismatched++;
          $display("FAIL pix seg=%0d p=%0d: entry never reached (now seg=%0d p=%0d)", e.seg, e.p, seg, p);
        end else if ({data, active, frame_start, mode_ack} !== {e.data, e.act, e.fs, e.ack}) begin
          mismatched++;
          $display("FAIL pix seg=%0d p=%0d: got data=%h active=%b fs=%b ack=%b, want data=%h active=%b fs=%b ack=%b",
                   seg, p, data, active, frame_start, mode_ack, e.data, e.act, e.fs, e.ack);
        end
      end
    end
  end

  task automatic push(input int s, input int p, input logic [7:0] d,
                      input logic a, input logic f, input logic k);
    exp_t e;
    e.seg = s; e.p = p; e.data = d; e.act = a; e.fs = f; e.ack = k;
    q.push_back(e);
  endtask

  task automatic wait_to(input int p);
    do @(negedge dclk); while (n - 1 < p);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode_req = 1'b0; mode_sel = 2'd0; fill_color = 8'h00;

    // Frame 0: default bars, request solid 0xAA mid-frame
    push(0, -1,   8'h00, 0, 0, 0);
    push(0, 0,    8'hFF, 1, 1, 0);
    push(0, 15,   8'h3F, 1, 0, 0);
    push(0, 79,   8'h00, 1, 0, 0);
    push(0, 80,   8'h00, 0, 0, 0);
    push(0, 99,   8'h00, 0, 0, 0);
    push(0, 325,  8'hF8, 1, 0, 0);
    push(0, 645,  8'hC7, 1, 0, 0);
    push(0, 1005, 8'h00, 0, 0, 0);
    push(0, 1199, 8'h00, 0, 0, 1);
    // Frame 1: solid 0xAA
    push(0, 1200, 8'hAA, 1, 1, 0);
    push(0, 1740, 8'hAA, 1, 0, 0);
    push(0, 2179, 8'hAA, 1, 0, 0);
    push(0, 2180, 8'h00, 0, 0, 0);
    push(0, 2399, 8'h00, 0, 0, 1);
    // Frame 2: checker with 0x07
    push(0, 2400, 8'h07, 1, 1, 0);
    push(0, 2404, 8'hF8, 1, 0, 0);
    push(0, 2800, 8'hF8, 1, 0, 0);
    push(0, 2804, 8'h07, 1, 0, 0);
    push(0, 3379, 8'hF8, 1, 0, 0);
    push(0, 3599, 8'h00, 0, 0, 1);
    // Frames 3..19: mode 3, offset equals frame number
`ifdef VGA_PATTERN_SCROLL_EN
    push(0, 3600,  8'hFF, 1, 1, 0);
    push(0, 3607,  8'h3F, 1, 0, 0);
    push(0, 3679,  8'hFF, 1, 0, 0);
    push(0, 3680,  8'h00, 0, 0, 0);
    push(0, 12000, 8'h3F, 1, 1, 0);
    push(0, 12075, 8'hFF, 1, 0, 0);
    push(0, 20462, 8'h00, 1, 0, 0);
    push(0, 20470, 8'hFF, 1, 0, 0);
    push(0, 22800, 8'h3F, 1, 1, 0);
`else
    push(0, 3600,  8'hFF, 1, 1, 0);
    push(0, 3607,  8'hFF, 1, 0, 0);
    push(0, 3679,  8'h00, 1, 0, 0);
    push(0, 3680,  8'h00, 0, 0, 0);
    push(0, 12000, 8'hFF, 1, 1, 0);
    push(0, 12075, 8'h00, 1, 0, 0);
    push(0, 20462, 8'hC0, 1, 0, 0);
    push(0, 20470, 8'h00, 1, 0, 0);
    push(0, 22800, 8'hFF, 1, 1, 0);
`endif

    repeat (3) @(posedge dclk);
    mon_en = 1'b1;
    @(negedge dclk);
    rst = 1'b0;

    wait_to(500);  mode_sel = 2'd0; fill_color = 8'hAA; mode_req = 1'b1;
    wait_to(1199); mode_req = 1'b0;
    wait_to(1300); mode_sel = 2'd2; fill_color = 8'h07; mode_req = 1'b1;
    wait_to(2399); mode_req = 1'b0;
    wait_to(2500); mode_sel = 2'd3; fill_color = 8'h00; mode_req = 1'b1;
    wait_to(2600); mode_req = 1'b0;
    wait_to(2650); mode_sel = 2'd0; fill_color = 8'h55; mode_req = 1'b1;
    wait_to(3599); mode_req = 1'b0;

    // Pending request discarded by reset
    wait_to(23000); mode_sel = 2'd0; fill_color = 8'h11; mode_req = 1'b1;
    wait_to(23500); rst = 1'b1; mode_req = 1'b0;
    @(posedge dclk);
    #1;
    seg = 1;
    push(1, -1,   8'h00, 0, 0, 0);
    push(1, 0,    8'hFF, 1, 1, 0);
    push(1, 15,   8'h3F, 1, 0, 0);
    push(1, 1199, 8'h00, 0, 0, 0);
    push(1, 1200, 8'hFF, 1, 1, 0);
    push(1, 1215, 8'h3F, 1, 0, 0);
    repeat (2) @(negedge dclk);
    rst = 1'b0;
    wait_to(1300);
    repeat (4) @(negedge dclk);

    compared++;
    if (ack_cnt != 3) begin
      mismatched++;
      $display("FAIL ack_count: got %0d, want 3", ack_cnt);
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
